// File: rtl/alu_scoreboard.sv
// Result checker for an ALU: expected results are queued, actual results are compared
// against the queue head. Optional macro ALU_SB_CARRY_CHECK_EN adds carry to the comparison.
module alu_scoreboard #(
    parameter int N     = 32,
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          exp_valid,
    input  logic [N-1:0]  exp_out,
    input  logic          exp_c_out,
    input  logic [2:0]    exp_op,
    output logic          exp_ready,
    input  logic          act_valid,
    input  logic [N-1:0]  act_out,
    input  logic          act_c_out,
    output logic          error_flag,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] pass_count,
    output logic [2:0]    first_op,
    output logic [N-1:0]  first_exp,
    output logic [N-1:0]  first_act,
    output logic          underflow,
    output logic          busy,
    output logic          done
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    res_mem [DEPTH];
    logic [2:0]      op_mem  [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, empty, active, clear, push, check_req, pop, miss, match;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign active    = (state == RUN) || (state == DRAIN);
    assign clear     = start && ((state == IDLE) || (state == DONE));
    assign exp_ready = (state == RUN) && !full;
    assign push      = exp_valid && exp_ready;
    assign check_req = act_valid && active;
    assign pop       = check_req && !empty;
    assign miss      = check_req && empty;
    assign busy      = active;
    assign done      = (state == DONE);

`ifdef ALU_SB_CARRY_CHECK_EN
    logic c_mem [DEPTH];
    assign match = (act_out == res_mem[rd_ptr]) && (act_c_out == c_mem[rd_ptr]);

    always_ff @(posedge clk) begin
        if (push) c_mem[wr_ptr] <= exp_c_out;
    end
`else
    logic unused_carry;
    assign unused_carry = exp_c_out ^ act_c_out;
    assign match        = (act_out == res_mem[rd_ptr]);
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (stop)  state_nxt = DRAIN;
            // No push can be accepted outside RUN, so an empty queue here is final.
            DRAIN:   if (empty) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: queue storage has no reset; occupancy and pointers alone define valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr] <= exp_out;
            op_mem[wr_ptr]  <= exp_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_flag <= 1'b0;
            underflow  <= 1'b0;
            err_count  <= '0;
            pass_count <= '0;
            first_op   <= '0;
            first_exp  <= '0;
            first_act  <= '0;
        end else if (clear) begin
            error_flag <= 1'b0;
            underflow  <= 1'b0;
            err_count  <= '0;
            pass_count <= '0;
            first_op   <= '0;
            first_exp  <= '0;
            first_act  <= '0;
        end else begin
            if (miss) begin
                underflow  <= 1'b1;
                error_flag <= 1'b1;
            end
            if (pop) begin
                if (match) begin
                    if (pass_count != '1) pass_count <= pass_count + 1'b1;
                end else begin
                    if (err_count != '1) err_count <= err_count + 1'b1;
                    error_flag <= 1'b1;
                    // Counter still zero means this is the run's first mismatch.
                    if (err_count == '0) begin
                        first_op  <= op_mem[rd_ptr];
                        first_exp <= res_mem[rd_ptr];
                        first_act <= act_out;
                    end
                end
            end
        end
    end

endmodule

// File: doc/alu_scoreboard.md
ALU_SCOREBOARD -- requirements
Module: alu_scoreboard

Interface
REQ-001 Parameter N, default 32, datapath width of compared results.
REQ-002 Parameter DEPTH, default 8, expected-result queue entries (power of two, >=2).
REQ-003 Parameter CW, default 16, counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a check run.
REQ-007 stop  input  1  one-cycle pulse; ends the run after the queue drains.
REQ-008 exp_valid  input  1  push expected result into queue.
REQ-009 exp_out  input  N  expected ALU result.
REQ-010 exp_c_out  input  1  expected carry.
REQ-011 exp_op  input  3  ALUOp tag of expected entry.
REQ-012 exp_ready  output  1  queue can accept a push.
REQ-013 act_valid  input  1  actual ALU result present; pops queue head.
REQ-014 act_out  input  N  actual ALU result.
REQ-015 act_c_out  input  1  actual carry.
REQ-016 error_flag  output  1  sticky, any mismatch or underflow this run.
REQ-017 err_count, pass_count  output  CW each  mismatch and match totals.
REQ-018 first_op, first_exp, first_act  output  3/N/N  captured data of first mismatch.
REQ-019 underflow  output  1  sticky, act_valid seen with empty queue.
REQ-020 busy, done  output  1 each  run active; run complete.

Function
REQ-021 States IDLE, RUN, DRAIN, DONE; encoding left to implementer.
REQ-022 IDLE->RUN on start, clearing counters, sticky flags, capture registers and queue in that same edge.
REQ-023 RUN->DRAIN on stop; DRAIN->DONE on the first cycle queue is empty with no push; DONE->RUN on start (same clearing as REQ-022).
REQ-024 start in RUN or DRAIN is ignored; stop outside RUN is ignored.
REQ-025 Pushes accepted only in RUN when exp_valid and exp_ready; exp_ready = RUN and queue not full.
REQ-026 Pops/compares occur in RUN and DRAIN when act_valid; actual compared against queue head in the same cycle, result visible in counters/flags one cycle later.
REQ-027 Match: act_out==exp_out (and carry per REQ-036) -> pass_count+1; else err_count+1, error_flag=1.
REQ-028 First mismatch of a run loads first_op/first_exp/first_act; later mismatches do not overwrite.
REQ-029 act_valid with empty queue: no pop, no count change, underflow=1, error_flag=1; a same-cycle push is still stored.
REQ-030 Simultaneous push and pop when full: pop occurs, push rejected (exp_ready low); occupancy becomes DEPTH-1.
REQ-031 Simultaneous push and pop when non-empty and non-full: occupancy unchanged, order preserved (FIFO).
REQ-032 Pointers wrap modulo DEPTH; counters saturate at all-ones, never wrap.
REQ-033 busy=1 in RUN and DRAIN; done=1 only in DONE; act_valid in IDLE/DONE ignored.

Reset
REQ-034 rst asserted at any time, including mid-run: state IDLE, queue empty, all counters, flags, capture registers 0, exp_ready 0, busy 0, done 0.
REQ-035 No output depends on state older than the last rst deassertion.

Configuration
REQ-036 Macro ALU_SB_CARRY_CHECK_EN: defined -> match also requires act_c_out==exp_c_out and carry stored in queue; undefined -> carry ignored, not stored, exp_c_out/act_c_out unused.

Verification
REQ-037 start; push 5 ADD entries (1000+999=1999, ...); 5 matching actuals; stop -> pass_count=5, err_count=0, error_flag=0, done=1.
REQ-038 Push exp_out=0xFFFFFFFE, act_out=0xFFFFFFFF then second mismatch 0x1 vs 0x2 -> err_count=2, first_exp=0xFFFFFFFE, first_act=0xFFFFFFFF, first_op as pushed.
REQ-039 Push DEPTH entries, exp_ready=0; push+pop same cycle -> occupancy DEPTH-1, pushed value dropped, remaining order intact.
REQ-040 act_valid with empty queue in RUN -> underflow=1, error_flag=1, counters unchanged.
REQ-041 With macro defined, exp 0x00000001/c=1 vs act 0x00000001/c=0 -> err_count=1; undefined -> pass_count=1.
REQ-042 rst pulse during DRAIN with 3 queued entries -> next cycle all outputs 0, state IDLE; subsequent start runs clean.
